// File: rtl/checker_pkg.sv
// Shared state encoding and error codes for the checker_* MPU sequencing blocks.
// Pure declarations: no latency, no flow control.
package checker_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_SLEEP = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_MPU  = 2'b01;
  localparam logic [1:0] ERR_WDOG = 2'b10;

endpackage

// File: rtl/checker_downcnt.sv
// Loadable down-counter with an is-one flag; load wins over decrement, holds at zero.
// Flag is registered-state based (valid the cycle after load), no backpressure.
module checker_downcnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_is_one
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_value;

  // Zero means "disarmed": never decrements, never reports one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
    end else if (i_dec && (r_value != '0)) begin
      r_value <= r_value - ONE;
    end
  end

  assign o_is_one = (r_value == ONE);

endmodule

// File: rtl/checker_periodic.sv
// Periodic MPU run sequencer: reset/run/sleep passes with watchdog, IRQ handoff and pass counting.
// Outputs registered (one cycle after the deciding input); IRQ holds in WAIT until mode_ack.
module checker_periodic
  import checker_pkg::*;
#(
  parameter logic [1:0] MODE = 2'b00,
  parameter int         DW   = 64,
  parameter int         CW   = 32,
  parameter int         TW   = 32
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic [1:0]    mode_mode,
  input  logic          mode_start,
  input  logic [CW-1:0] mode_period,
  input  logic [CW-1:0] mode_count,
  input  logic [TW-1:0] mode_timeout,
  output logic          mode_end,
  output logic          mode_error,
  output logic [1:0]    mode_err_code,
  output logic          mode_irq,
  output logic [DW-1:0] mode_data,
  input  logic          mode_ack,
  output logic [CW-1:0] mode_passes,
  input  logic          mpu_error,
  input  logic          mpu_user_irq,
  input  logic [DW-1:0] mpu_user_data,
  output logic          mpu_en,
  output logic          mpu_rst
);

  localparam int KW = (CW > TW) ? CW : TW;
  localparam logic [CW-1:0] ONE_CW = {{(CW-1){1'b0}}, 1'b1};

  state_t        r_state, w_state_nxt;
  logic          r_mpu_en, w_mpu_en_nxt;
  logic          r_mpu_rst, w_mpu_rst_nxt;
  logic          r_irq, w_irq_nxt;
  logic [DW-1:0] r_data, w_data_nxt;
  logic          r_end, w_end_nxt;
  logic          r_error, w_error_nxt;
  logic [1:0]    r_code, w_code_nxt;
  logic [CW-1:0] r_passes, w_passes_nxt;
  logic [CW-1:0] r_period, w_period_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [TW-1:0] r_timeout, w_timeout_nxt;

  logic          w_cnt_load;
  logic [KW-1:0] w_cnt_val;
  logic          w_cnt_dec;
  logic          w_cnt_one;
  logic [CW-1:0] w_passes_inc;

  assign w_passes_inc = (&r_passes) ? r_passes : (r_passes + ONE_CW);

  // Watchdog (RUN) and sleep gap (SLEEP) are never live together, so one counter serves both.
  checker_downcnt #(.W(KW)) u_downcnt (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_is_one   (w_cnt_one)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_mpu_en_nxt  = r_mpu_en;
    w_mpu_rst_nxt = r_mpu_rst;
    w_irq_nxt     = r_irq;
    w_data_nxt    = r_data;
    w_end_nxt     = r_end;
    w_error_nxt   = r_error;
    w_code_nxt    = r_code;
    w_passes_nxt  = r_passes;
    w_period_nxt  = r_period;
    w_count_nxt   = r_count;
    w_timeout_nxt = r_timeout;
    w_cnt_load    = 1'b0;
    w_cnt_val     = '0;
    w_cnt_dec     = 1'b0;

    if ((r_state != ST_IDLE) && (mode_mode != MODE)) begin
      w_state_nxt   = ST_IDLE;
      w_mpu_en_nxt  = 1'b0;
      w_mpu_rst_nxt = 1'b0;
      w_irq_nxt     = 1'b0;
      w_data_nxt    = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (mode_start && (mode_mode == MODE)) begin
            w_period_nxt  = mode_period;
            w_count_nxt   = mode_count;
            w_timeout_nxt = mode_timeout;
            w_passes_nxt  = '0;
            w_end_nxt     = 1'b0;
            w_error_nxt   = 1'b0;
            w_code_nxt    = ERR_NONE;
            w_mpu_rst_nxt = 1'b1;
            w_state_nxt   = ST_RESET;
          end
        end
        ST_RESET: begin
          w_mpu_rst_nxt = 1'b0;
          w_mpu_en_nxt  = 1'b1;
          w_cnt_load    = 1'b1;
          w_cnt_val     = KW'(r_timeout);
          w_state_nxt   = ST_RUN;
        end
        ST_RUN: begin
          w_cnt_dec = 1'b1;
          if (!mode_start) begin
            w_mpu_en_nxt = 1'b0;
            w_state_nxt  = ST_IDLE;
          end else if (mpu_error) begin
            w_mpu_en_nxt = 1'b0;
            w_error_nxt  = 1'b1;
            w_code_nxt   = ERR_MPU;
            w_state_nxt  = ST_IDLE;
          end else if (mpu_user_irq) begin
            w_mpu_en_nxt = 1'b0;
            if (mpu_user_data != '0) begin
              w_data_nxt  = mpu_user_data;
              w_irq_nxt   = 1'b1;
              w_state_nxt = ST_WAIT;
            end else begin
              // Zero-data IRQ marks the end of a pass.
              w_passes_nxt = w_passes_inc;
              if ((r_count != '0) && (w_passes_inc == r_count)) begin
                w_end_nxt   = 1'b1;
                w_state_nxt = ST_IDLE;
              end else if (r_period == '0) begin
                w_mpu_rst_nxt = 1'b1;
                w_state_nxt   = ST_RESET;
              end else begin
                w_cnt_load  = 1'b1;
                w_cnt_val   = KW'(r_period);
                w_state_nxt = ST_SLEEP;
              end
            end
          end else if (w_cnt_one) begin
            w_mpu_en_nxt = 1'b0;
            w_error_nxt  = 1'b1;
            w_code_nxt   = ERR_WDOG;
            w_state_nxt  = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (!mode_start) begin
            w_irq_nxt   = 1'b0;
            w_data_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end else if (mode_ack) begin
            w_irq_nxt    = 1'b0;
            w_data_nxt   = '0;
            w_mpu_en_nxt = 1'b1;
            w_state_nxt  = ST_RUN;
          end
        end
        ST_SLEEP: begin
          w_cnt_dec = 1'b1;
          if (!mode_start) begin
            w_state_nxt = ST_IDLE;
          end else if (w_cnt_one) begin
            w_mpu_rst_nxt = 1'b1;
            w_state_nxt   = ST_RESET;
          end
        end
        default: begin
          w_mpu_en_nxt  = 1'b0;
          w_mpu_rst_nxt = 1'b0;
          w_state_nxt   = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_IDLE;
      r_mpu_en  <= 1'b0;
      r_mpu_rst <= 1'b0;
      r_irq     <= 1'b0;
      r_data    <= '0;
      r_end     <= 1'b0;
      r_error   <= 1'b0;
      r_code    <= ERR_NONE;
      r_passes  <= '0;
      r_period  <= '0;
      r_count   <= '0;
      r_timeout <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_mpu_en  <= w_mpu_en_nxt;
      r_mpu_rst <= w_mpu_rst_nxt;
      r_irq     <= w_irq_nxt;
      r_data    <= w_data_nxt;
      r_end     <= w_end_nxt;
      r_error   <= w_error_nxt;
      r_code    <= w_code_nxt;
      r_passes  <= w_passes_nxt;
      r_period  <= w_period_nxt;
      r_count   <= w_count_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign mpu_en        = r_mpu_en;
  assign mpu_rst       = r_mpu_rst;
  assign mode_irq      = r_irq;
  assign mode_data     = r_data;
  assign mode_end      = r_end;
  assign mode_error    = r_error;
  assign mode_err_code = r_code;
  assign mode_passes   = r_passes;

endmodule

// File: tb/tb_checker_periodic.sv
// Directed bench for checker_periodic: cycle vector table plus multi-cycle pass/watchdog/reset sequences.
module tb_checker_periodic;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [1:0]  mode_mode;
  logic        mode_start;
  logic [31:0] mode_period;
  logic [31:0] mode_count;
  logic [31:0] mode_timeout;
  logic        mode_end;
  logic        mode_error;
  logic [1:0]  mode_err_code;
  logic        mode_irq;
  logic [63:0] mode_data;
  logic        mode_ack;
  logic [31:0] mode_passes;
  logic        mpu_error;
  logic        mpu_user_irq;
  logic [63:0] mpu_user_data;
  logic        mpu_en;
  logic        mpu_rst;

  checker_periodic dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .mode_mode     (mode_mode),
    .mode_start    (mode_start),
    .mode_period   (mode_period),
    .mode_count    (mode_count),
    .mode_timeout  (mode_timeout),
    .mode_end      (mode_end),
    .mode_error    (mode_error),
    .mode_err_code (mode_err_code),
    .mode_irq      (mode_irq),
    .mode_data     (mode_data),
    .mode_ack      (mode_ack),
    .mode_passes   (mode_passes),
    .mpu_error     (mpu_error),
    .mpu_user_irq  (mpu_user_irq),
    .mpu_user_data (mpu_user_data),
    .mpu_en        (mpu_en),
    .mpu_rst       (mpu_rst)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic        en;
    logic        rst;
    logic        irq;
    logic        done;
    logic        err;
    logic [1:0]  code;
    logic [63:0] data;
    logic [31:0] passes;
  } out_t;

  typedef struct {
    logic        start;
    logic [1:0]  mode;
    logic        merr;
    logic        irq;
    logic [15:0] udata;
    logic        ack;
    out_t        exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  vec_t vt [19];

  function automatic out_t obs();
    return {mpu_en, mpu_rst, mode_irq, mode_end, mode_error, mode_err_code, mode_data, mode_passes};
  endfunction

  function automatic vec_t mk(logic st, logic [1:0] md, logic me, logic ir, logic [15:0] ud, logic ak,
                              logic en, logic rs, logic iq, logic dn, logic er, logic [1:0] cd,
                              logic [15:0] dat, logic [7:0] ps);
    vec_t v;
    v.start = st; v.mode = md; v.merr = me; v.irq = ir; v.udata = ud; v.ack = ak;
    v.exp.en = en; v.exp.rst = rs; v.exp.irq = iq; v.exp.done = dn; v.exp.err = er;
    v.exp.code = cd; v.exp.data = {48'd0, dat}; v.exp.passes = {24'd0, ps};
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  int run_len, gap_len, npass, bad;
  bit in_gap, fin;

  initial begin
    sys_rst_n = 1'b0;
    mode_mode = 2'b00; mode_start = 1'b0; mode_ack = 1'b0;
    mode_period = 0; mode_count = 0; mode_timeout = 0;
    mpu_error = 1'b0; mpu_user_irq = 1'b0; mpu_user_data = '0;

    //        st md me ir ud     ak | en rs iq dn er cd     dat    ps
    vt[0]  = mk(1, 0, 0, 0, 0,     0,  0, 1, 0, 0, 0, 2'b00, 0,     0);
    vt[1]  = mk(1, 0, 0, 0, 0,     0,  1, 0, 0, 0, 0, 2'b00, 0,     0);
    vt[2]  = mk(1, 0, 0, 1, 0,     0,  0, 1, 0, 0, 0, 2'b00, 0,     1);
    vt[3]  = mk(1, 0, 0, 0, 0,     0,  1, 0, 0, 0, 0, 2'b00, 0,     1);
    vt[4]  = mk(1, 0, 0, 1, 'hAB,  0,  0, 0, 1, 0, 0, 2'b00, 'hAB, 1);
    vt[5]  = mk(1, 0, 0, 0, 0,     0,  0, 0, 1, 0, 0, 2'b00, 'hAB, 1);
    vt[6]  = mk(1, 0, 0, 0, 0,     1,  1, 0, 0, 0, 0, 2'b00, 0,     1);
    vt[7]  = mk(1, 0, 0, 1, 0,     0,  0, 0, 0, 1, 0, 2'b00, 0,     2);
    vt[8]  = mk(1, 0, 0, 0, 0,     0,  0, 1, 0, 0, 0, 2'b00, 0,     0);
    vt[9]  = mk(1, 0, 0, 0, 0,     0,  1, 0, 0, 0, 0, 2'b00, 0,     0);
    vt[10] = mk(1, 0, 1, 1, 5,     0,  0, 0, 0, 0, 1, 2'b01, 0,     0);
    vt[11] = mk(0, 0, 0, 0, 0,     0,  0, 0, 0, 0, 1, 2'b01, 0,     0);
    vt[12] = mk(1, 1, 0, 0, 0,     0,  0, 0, 0, 0, 1, 2'b01, 0,     0);
    vt[13] = mk(1, 0, 0, 0, 0,     0,  0, 1, 0, 0, 0, 2'b00, 0,     0);
    vt[14] = mk(1, 0, 0, 0, 0,     0,  1, 0, 0, 0, 0, 2'b00, 0,     0);
    vt[15] = mk(1, 1, 0, 0, 0,     0,  0, 0, 0, 0, 0, 2'b00, 0,     0);
    vt[16] = mk(1, 0, 0, 0, 0,     0,  0, 1, 0, 0, 0, 2'b00, 0,     0);
    vt[17] = mk(1, 0, 0, 0, 0,     0,  1, 0, 0, 0, 0, 2'b00, 0,     0);
    vt[18] = mk(0, 0, 0, 1, 0,     0,  0, 0, 0, 0, 0, 2'b00, 0,     0);

    #12;
    chk("reset_state", obs(), '0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Cycle table: count=2, period=0, watchdog off.
    mode_count = 2; mode_period = 0; mode_timeout = 0;
    for (int i = 0; i < 19; i++) begin
      mode_start = vt[i].start; mode_mode = vt[i].mode; mpu_error = vt[i].merr;
      mpu_user_irq = vt[i].irq; mpu_user_data = {48'd0, vt[i].udata}; mode_ack = vt[i].ack;
      @(negedge sys_clk);
      chk($sformatf("vec%0d", i), obs(), vt[i].exp);
    end
    mode_start = 0; mode_mode = 0; mpu_error = 0; mpu_user_irq = 0; mpu_user_data = '0; mode_ack = 0;
    repeat (2) @(negedge sys_clk);

    // Bounded run: 3 passes of 10 RUN cycles, 4-cycle sleep gaps.
    mode_count = 3; mode_period = 4; mode_timeout = 0; mode_start = 1;
    run_len = 0; gap_len = 0; in_gap = 0; npass = 0; fin = 0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge sys_clk);
      if (mpu_en) begin
        run_len++;
        mpu_user_irq = (run_len == 10);
      end else begin
        mpu_user_irq = 0;
        if (run_len > 0) begin
          chk("a_run_len", run_len, 10);
          npass++; run_len = 0; in_gap = 1; gap_len = 0;
        end
        if (mode_end) fin = 1;
        else if (in_gap) begin
          if (mpu_rst) begin chk("a_sleep_gap", gap_len, 4); in_gap = 0; end
          else gap_len++;
        end
      end
    end
    mode_start = 0;
    chk("a_done", fin, 1);
    chk("a_final", {npass, mode_passes, mode_end, mpu_en}, {32'd3, 32'd3, 1'b1, 1'b0});
    repeat (2) @(negedge sys_clk);

    // Watchdog: timeout 5, MPU silent.
    mode_count = 0; mode_period = 0; mode_timeout = 5; mode_start = 1;
    run_len = 0; fin = 0;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge sys_clk);
      if (mpu_en) run_len++;
      else if (mode_error) fin = 1;
    end
    mode_start = 0;
    chk("b_done", fin, 1);
    chk("b_en_len", run_len, 5);
    chk("b_flags", {mode_error, mode_err_code, mpu_en}, {1'b1, 2'b10, 1'b0});
    repeat (2) @(negedge sys_clk);

    // IRQ handoff with frozen watchdog: timeout 8, IRQ on RUN cycle 3, ack 20 cycles later.
    mode_timeout = 8; mode_start = 1;
    run_len = 0; fin = 0;
    for (int c = 0; c < 50 && !fin; c++) begin
      @(negedge sys_clk);
      if (mpu_en) begin
        run_len++;
        if (run_len == 3) begin mpu_user_irq = 1; mpu_user_data = 64'hDEAD; fin = 1; end
      end
    end
    chk("c_reach", fin, 1);
    @(negedge sys_clk);
    mpu_user_irq = 0; mpu_user_data = '0;
    chk("c_irq", {mode_irq, mode_data, mpu_en}, {1'b1, 64'hDEAD, 1'b0});
    repeat (19) @(negedge sys_clk);
    chk("c_hold", {mode_irq, mode_data, mpu_en, mode_error}, {1'b1, 64'hDEAD, 1'b0, 1'b0});
    mode_ack = 1;
    @(negedge sys_clk);
    mode_ack = 0;
    chk("c_ack", {mode_irq, mode_data, mpu_en}, {1'b0, 64'h0, 1'b1});
    run_len = 1; fin = 0;
    for (int c = 0; c < 50 && !fin; c++) begin
      @(negedge sys_clk);
      if (mpu_en) run_len++;
      else if (mode_error) fin = 1;
    end
    mode_start = 0;
    chk("c_rest_len", run_len, 5);
    chk("c_wdog", {fin, mode_err_code}, {1'b1, 2'b10});
    repeat (2) @(negedge sys_clk);

    // Unbounded back-to-back passes, start dropped during pass 7.
    mode_count = 0; mode_period = 0; mode_timeout = 0; mode_start = 1;
    run_len = 0; npass = 0; fin = 0; bad = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      @(negedge sys_clk);
      if (mpu_en) begin
        run_len++;
        if (npass == 6) begin mode_start = 0; mpu_user_irq = 0; fin = 1; end
        else mpu_user_irq = (run_len == 2);
      end else begin
        mpu_user_irq = 0;
        if (run_len > 0) begin
          npass++; run_len = 0;
          if (!mpu_rst) bad++;
        end
      end
    end
    chk("d_reach", fin, 1);
    chk("d_b2b_reset", bad, 0);
    @(negedge sys_clk);
    chk("d_final", {mode_passes, mode_end, mpu_en}, {32'd6, 1'b0, 1'b0});
    repeat (2) @(negedge sys_clk);

    // Asynchronous reset while sleeping.
    mode_count = 0; mode_period = 50; mode_timeout = 0; mode_start = 1;
    run_len = 0; fin = 0;
    for (int c = 0; c < 50 && !fin; c++) begin
      @(negedge sys_clk);
      if (mpu_en) begin
        run_len++;
        mpu_user_irq = (run_len == 2);
      end else begin
        mpu_user_irq = 0;
        if (run_len > 0) fin = 1;
      end
    end
    repeat (3) @(negedge sys_clk);
    chk("e_sleeping", {fin, mpu_en, mpu_rst, mode_passes}, {1'b1, 1'b0, 1'b0, 32'd1});
    #2 sys_rst_n = 0;
    #1 chk("e_async", obs(), '0);
    @(negedge sys_clk);
    mode_start = 0;
    @(negedge sys_clk);
    sys_rst_n = 1;
    repeat (3) @(negedge sys_clk);
    chk("e_idle", obs(), '0);
    mode_start = 1;
    @(negedge sys_clk);
    chk("e_restart", {mpu_rst, mpu_en}, {1'b1, 1'b0});
    mode_start = 0;
    repeat (3) @(negedge sys_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
